byte_encode_stream: RTL and testbench

Streaming ByteEncode_ell for Kyber-768-90s. The block takes one polynomial of NUM_COEFFS ELL-bit coefficients, one coefficient per handshake, and emits the packed byte stream, one byte per handshake. Bits are packed LSB-first, so it is the exact inverse of the combinational decode block: a 256-coefficient polynomial produces 32·ELL bytes. It sits in the key-generation and encryption serialisation path, between the NTT/compress output and the public-key/ciphertext byte buffer.

---
 rtl/byte_encode_stream.sv | 142 ++++++++++++++
 tb/tb_byte_encode_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_encode_stream.sv
// byte_encode_stream: streaming ByteEncode_ell packer. Takes one polynomial of
// NUM_COEFFS ELL-bit coefficients, one per handshake, and emits the
// LSB-first packed byte stream, one byte per handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse that begins a polynomial (ignored while busy)
//   coeff/coeff_valid/coeff_ready   coefficient input handshake
//   byte_data/byte_valid/byte_ready packed byte output handshake
//   busy                  polynomial in progress
//   done                  one-cycle pulse after the last byte is accepted
//   range_err             sticky: an accepted coeff was >= 3329 (ELL=12 only)
//
// state | meaning
// IDLE  | waiting for start, both handshakes closed
// RUN   | packing: accepting coefficients and emitting bytes
// DONE  | one-cycle done pulse, then back to IDLE
module byte_encode_stream #(
  parameter int ELL        = 12,
  parameter int NUM_COEFFS = 256,
  parameter int BYTE_COUNT = NUM_COEFFS * ELL / 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [ELL-1:0] coeff,
  input  logic           coeff_valid,
  output logic           coeff_ready,
  output logic [7:0]     byte_data,
  output logic           byte_valid,
  input  logic           byte_ready,
  output logic           busy,
  output logic           done,
  output logic           range_err
);

  localparam int ACC_W       = ELL + 8;
  localparam int CNT_W       = $clog2(ELL + 8);
  localparam int CCNT_W      = $clog2(NUM_COEFFS + 1);
  localparam int BL_W        = $clog2(BYTE_COUNT + 1);
  localparam bit CHECK_RANGE = (ELL == 12);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [CCNT_W-1:0] ccnt;
  logic [BL_W-1:0]   bytes_left;

  logic [ACC_W-1:0]  acc_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [CCNT_W-1:0] ccnt_n;
  logic [BL_W-1:0]   bytes_left_n;
  logic              coeff_hs;
  logic              byte_hs;
  logic              last_byte;
  logic [11:0]       coeff12;

  assign byte_data = acc[7:0];
  assign coeff12   = 12'(coeff);
  assign coeff_hs  = (state == RUN) && coeff_valid && coeff_ready;
  assign byte_hs   = (state == RUN) && byte_valid && byte_ready;
  // Down-counter of remaining bytes; reaching its terminal count coincides
  // with ccnt = NUM_COEFFS and cnt draining to 0.
  assign last_byte = byte_hs && (bytes_left == BL_W'(1));

  // The registered ready/valid guarantee at most one of the two handshakes
  // per cycle, so the updates below never collide.
  always_comb begin
    acc_n        = acc;
    cnt_n        = cnt;
    ccnt_n       = ccnt;
    bytes_left_n = bytes_left;
    if (coeff_hs) begin
      acc_n  = acc | (ACC_W'(coeff) << cnt);
      cnt_n  = cnt + CNT_W'(ELL);
      ccnt_n = ccnt + CCNT_W'(1);
    end
    if (byte_hs) begin
      acc_n        = acc >> 8;
      cnt_n        = cnt - CNT_W'(8);
      bytes_left_n = bytes_left - BL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ccnt        <= '0;
      bytes_left  <= '0;
      coeff_ready <= 1'b0;
      byte_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= RUN;
            acc         <= '0;
            cnt         <= '0;
            ccnt        <= '0;
            bytes_left  <= BL_W'(BYTE_COUNT);
            range_err   <= 1'b0;
            busy        <= 1'b1;
            coeff_ready <= 1'b1;
            byte_valid  <= 1'b0;
          end
        end
        RUN: begin
          acc        <= acc_n;
          cnt        <= cnt_n;
          ccnt       <= ccnt_n;
          bytes_left <= bytes_left_n;
          if (coeff_hs && CHECK_RANGE && (coeff12 >= 12'd3329))
            range_err <= 1'b1;
          if (last_byte) begin
            state       <= DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            coeff_ready <= 1'b0;
            byte_valid  <= 1'b0;
          end else begin
            coeff_ready <= (ccnt_n < CCNT_W'(NUM_COEFFS)) && (cnt_n < CNT_W'(8));
            byte_valid  <= (cnt_n >= CNT_W'(8));
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_encode_stream.sv
module tb_byte_encode_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s12, cv12, cr12, bv12, br12, busy12, done12, re12;
  logic [11:0] c12;
  logic [7:0]  bd12;

  logic        s1, c1, cv1, cr1, bv1, br1, busy1, done1, re1;
  logic [7:0]  bd1;

  int tests = 0;
  int fails = 0;

  int         coeffs[$];
  logic [7:0] expq[$];
  logic [7:0] got[$];
  bit         bitq[$];

  int nbytes, ndone, runcyc;

  byte_encode_stream #(.ELL(12), .NUM_COEFFS(256)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(s12), .coeff(c12), .coeff_valid(cv12),
    .coeff_ready(cr12), .byte_data(bd12), .byte_valid(bv12), .byte_ready(br12),
    .busy(busy12), .done(done12), .range_err(re12)
  );

  byte_encode_stream #(.ELL(1), .NUM_COEFFS(256)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .coeff(c1), .coeff_valid(cv1),
    .coeff_ready(cr1), .byte_data(bd1), .byte_valid(bv1), .byte_ready(br1),
    .busy(busy1), .done(done1), .range_err(re1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference packer: flattens coefficients into a bit stream, LSB first.
  task automatic model_push(input int v);
    logic [7:0] b;
    for (int j = 0; j < 12; j++) bitq.push_back(v[j]);
    while (bitq.size() >= 8) begin
      b = '0;
      for (int k = 0; k < 8; k++) b[k] = bitq.pop_front();
      expq.push_back(b);
    end
  endtask

  task automatic decode_check();
    logic [7:0]  b;
    logic [31:0] v;
    int          k;
    if (got.size() != coeffs.size() * 12 / 8) return;
    for (int i = 0; i < coeffs.size(); i++) begin
      v = '0;
      for (int j = 0; j < 12; j++) begin
        k = i * 12 + j;
        b = got[k / 8];
        v[j] = b[k % 8];
      end
      check("decode", v, coeffs[i]);
    end
  endtask

  task automatic fill_random();
    coeffs.delete();
    for (int i = 0; i < 256; i++) coeffs.push_back(int'($urandom_range(3328)));
  endtask

  task automatic start12();
    @(negedge clk);
    check("done_single_cycle", done12, 0);
    s12 = 1'b1;
    @(negedge clk);
    s12 = 1'b0;
    check("busy_after_start", busy12, 1);
    check("ready_after_start", cr12, 1);
    check("range_err_cleared", re12, 0);
  endtask

  // Runs from the negedge right after start12 until done is seen (or abort).
  task automatic run12(input int gap, input int stall, input int abort_after, input int poke_at);
    int         idx;
    bit         re_model;
    bit         stalled;
    bit         do_abort;
    bit         fin;
    logic [7:0] held;
    int         cyc;
    idx = 0; re_model = 0; stalled = 0; do_abort = 0; fin = 0; held = '0; cyc = 0;
    nbytes = 0; ndone = 0; runcyc = 0;
    expq.delete(); bitq.delete(); got.delete();
    while (!fin) begin
      if (do_abort) begin
        rst_n = 1'b0;
        #1;
        check("abort_coeff_ready", cr12, 0);
        check("abort_byte_valid", bv12, 0);
        check("abort_byte_data", bd12, 0);
        check("abort_busy", busy12, 0);
        check("abort_done", done12, 0);
        check("abort_range_err", re12, 0);
        cv12 = 1'b0; br12 = 1'b0;
        fin = 1;
      end else begin
        if (busy12) runcyc++;
        check("ready_valid_exclusive", cr12 & bv12, 0);
        check("range_err", re12, re_model);
        if (stalled) begin
          check("stall_valid", bv12, 1);
          check("stall_data", bd12, held);
        end
        if (done12) begin
          ndone++;
          check("busy_low_at_done", busy12, 0);
          cv12 = 1'b0; br12 = 1'b0; s12 = 1'b0;
          fin = 1;
        end else begin
          s12  = (cyc == poke_at);
          cv12 = (idx < coeffs.size()) && ($urandom_range(99) >= gap);
          c12  = cv12 ? 12'(coeffs[idx]) : 12'($urandom);
          br12 = ($urandom_range(99) >= stall);
          stalled = bv12 && !br12;
          held = bd12;
          if (cv12 && cr12) begin
            model_push(coeffs[idx]);
            if (coeffs[idx] >= 3329) re_model = 1;
            idx++;
            if (abort_after > 0 && idx == abort_after) do_abort = 1;
          end
          if (bv12 && br12) begin
            got.push_back(bd12);
            nbytes++;
            if (expq.size() > 0) check("byte", bd12, expq.pop_front());
            else begin
              tests++; fails++;
              $error("FAIL extra_byte: observed 0x%0h expected no byte", bd12);
            end
          end
        end
        cyc++;
        if (!fin && cyc > 20000) begin
          tests++; fails++;
          $error("FAIL frame_timeout: observed %0d cycles expected done", cyc);
          fin = 1;
        end
      end
      if (!fin) @(negedge clk);
    end
  endtask

  initial begin
    int idx1, nb1, nd1, cyc1;
    bit prevb;

    rst_n = 1'b0;
    s12 = 0; cv12 = 0; c12 = '0; br12 = 0;
    s1 = 0; cv1 = 0; c1 = 0; br1 = 0;
    #12;
    check("rst_coeff_ready", cr12, 0);
    check("rst_byte_valid", bv12, 0);
    check("rst_byte_data", bd12, 0);
    check("rst_busy", busy12, 0);
    check("rst_done", done12, 0);
    check("rst_range_err", re12, 0);
    check("rst_e1_busy", busy1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame A: known head, full throughput.
    fill_random();
    coeffs[0] = 'h123;
    coeffs[1] = 'h456;
    start12();
    run12(0, 0, 0, -1);
    check("A_bytes", nbytes, 384);
    check("A_done", ndone, 1);
    check("A_run_cycles", runcyc, 640);
    check("A_range_err", re12, 0);
    if (got.size() >= 3) begin
      check("A_byte0", got[0], 8'h23);
      check("A_byte1", got[1], 8'h61);
      check("A_byte2", got[2], 8'h45);
    end
    decode_check();

    // Frame B: gaps, stalls, start poked mid-frame; started right after done.
    fill_random();
    start12();
    run12(40, 50, 0, 50);
    check("B_bytes", nbytes, 384);
    check("B_done", ndone, 1);
    decode_check();

    // Frame C: out-of-range coefficient at index 5.
    fill_random();
    coeffs[5] = 3329;
    start12();
    run12(20, 30, 0, -1);
    check("C_bytes", nbytes, 384);
    check("C_range_err_through_done", re12, 1);
    decode_check();

    // Frame D: aborted by reset after 100 coefficients (start clears range_err).
    fill_random();
    start12();
    run12(10, 20, 100, -1);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame E: clean frame after the abort.
    fill_random();
    start12();
    run12(10, 10, 0, -1);
    check("E_bytes", nbytes, 384);
    check("E_done", ndone, 1);
    decode_check();

    // ELL=1: alternating 1,0 gives 0x55 bytes.
    @(negedge clk);
    s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    check("e1_busy_rise", busy1, 1);
    idx1 = 0; nb1 = 0; nd1 = 0; cyc1 = 0; prevb = 1;
    while (cyc1 < 2000) begin
      if (done1) begin
        nd1++;
        check("e1_busy_falls_with_done", busy1, 0);
        check("e1_busy_before_done", prevb, 1);
        break;
      end
      prevb = busy1;
      cv1 = (idx1 < 256);
      c1  = (idx1 % 2 == 0);
      br1 = 1'b1;
      if (bv1) begin
        check("e1_byte", bd1, 8'h55);
        nb1++;
      end
      if (cv1 && cr1) idx1++;
      cyc1++;
      @(negedge clk);
    end
    cv1 = 1'b0; br1 = 1'b0;
    if (nd1 == 0) begin
      tests++; fails++;
      $error("FAIL e1_timeout: observed %0d cycles expected done", cyc1);
    end
    check("e1_bytes", nb1, 32);
    check("e1_done", nd1, 1);
    check("e1_range_err", re1, 0);
    @(negedge clk);
    check("e1_done_single_cycle", done1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
